fir_coef_loader: RTL and testbench
==================================

Name: fir_coef_loader

Overview:
- Writer-side counterpart of the transposed-form FIR: produces the coefficient array `h[0:N-1]` that the filter consumes.
- Coefficients arrive from a host or control path as a serial valid/ready stream into a shadow bank.
- A complete, correctly framed set is swapped atomically into the active bank that drives the filter.
- The filter never sees a partially loaded set.

Parameters:
- N, 9, number of taps (must match the filter's N; N >= 2).
- COEF_W, 16, coefficient width, signed Q1.15 at the default width.
- UNITY, 32767, reset value of `h_out[0]`, giving a passthrough filter under the filter's >>>15 scaling.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  coefficient beat valid.
- s_ready  out  1  loader can accept a beat.
- s_data  in  COEF_W signed  coefficient value; beat k targets tap k.
- s_last  in  1  marks the final beat of a set.
- h_out  out  N x COEF_W signed (unpacked array [0:N-1])  active coefficients to the filter.
- swap  out  1  one-cycle pulse in the cycle after `h_out` changes.
- load_err  out  1  sticky framing error.
- busy  out  1  a set is partially received or a commit is pending.
- swap_count  out  8  number of successful swaps, wraps 255->0.

Behaviour:
- Reset (async assert, sync release):
  - `h_out[0]` = UNITY, `h_out[1..N-1]` = 0; shadow bank cleared.
  - idx = 0, state = LOAD, `s_ready` = 1.
  - `swap`, `load_err`, `busy` = 0; `swap_count` = 0.
- Beat accepted iff `s_valid && s_ready` at a rising clk edge.
- States:
  - LOAD:
    - An accepted beat writes shadow[idx]. `busy` = 1 whenever idx != 0.
    - If `s_last` and idx == N-1: go to COMMIT, idx <= 0.
    - If `s_last` and idx < N-1 (short set): discard the shadow contents, set `load_err`, idx <= 0, stay in LOAD. Active bank is untouched.
    - If no `s_last` and idx == N-1 (long set): go to DRAIN, idx <= 0.
    - Otherwise idx <= idx+1.
  - DRAIN:
    - `s_ready` = 1, `busy` = 1; accepted beats are discarded.
    - On an accepted beat with `s_last`: set `load_err`, go to LOAD. Active bank is untouched.
  - COMMIT (exactly one cycle):
    - `s_ready` = 0, `busy` = 1.
    - `h_out` <= shadow in one edge (all taps together), `swap_count` += 1, `load_err` cleared.
    - Return to LOAD.
    - `swap` = 1 in the following cycle, i.e. the first cycle `h_out` shows the new set; it is 0 at all other times.
- Latency: the final beat is accepted at edge E; `h_out` updates at edge E+2; `swap` is high during the cycle after E+2.
- Timing: `s_ready` is registered/state-derived with no combinational path from `s_valid`. Back-to-back sets are allowed; the next set's first beat is accepted in the cycle after COMMIT.
- `s_valid` low in mid-set: idx holds and there is no timeout.
- `load_err`:
  - Set on a short or long set.
  - Cleared only by a successful commit or by reset.
  - If an error and a commit would coincide, the commit wins; this cannot occur by construction, but the ordering is still required.
- Reset mid-set or mid-commit: the partial set is lost and `h_out` returns to the reset values. This is the only path that changes `h_out` other than COMMIT.
- Arithmetic: `s_data` is stored bit-exact with no saturation or scaling. `swap_count` is modulo 256.

Test Plan:
- Reset, then sample outputs → `h_out[0]` = 32767, `h_out[1..8]` = 0, `s_ready` = 1, `swap` = 0, `load_err` = 0, `swap_count` = 0.
- 9 consecutive beats with data 1..9, `s_last` on beat 9 → `h_out` = {1,…,9} exactly 2 cycles after the last accept; `swap` is a single-cycle pulse; `swap_count` = 1; `s_ready` = 0 for exactly the COMMIT cycle.
- Same set with `s_valid` toggled randomly and gaps of 0–5 cycles → identical final `h_out`; `h_out` is unchanged until the commit; `busy` = 1 throughout the set.
- Short set (5 beats, `s_last` on beat 5) → `load_err` = 1, `h_out` unchanged, no `swap`. A following valid 9-beat set of -1 values → all taps = -1 and `load_err` clears.
- Long set (12 beats, `s_last` on beat 12) → beats 10–12 are accepted and discarded, `load_err` = 1, `h_out` unchanged, `swap_count` unchanged.
- Assert `rst_n` low asynchronously after beat 4 of a set → outputs return to reset values immediately, without waiting for a clk edge. After release, a full 9-beat set loads correctly starting at tap 0.

Source files
------------

// File: rtl/fir_coef_loader.sv
// Coefficient loader for the transposed-form FIR. Serial beats fill a shadow bank,
// and only a correctly framed set of N beats is copied into the active bank, in a single edge.
module fir_coef_loader #(
    parameter int N      = 9,
    parameter int COEF_W = 16,
    parameter int UNITY  = 32767
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic signed [COEF_W-1:0] s_data,
    input  logic                     s_last,
    output logic signed [COEF_W-1:0] h_out [0:N-1],
    output logic                     swap,
    output logic                     load_err,
    output logic                     busy,
    output logic [7:0]               swap_count
);

    // state  | meaning
    // LOAD   | accepting beats into shadow[idx]
    // DRAIN  | set overran N taps; beats are swallowed until s_last
    // COMMIT | full set framed; s_ready low, copy to active bank on the following edge

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0]         LAST_IDX = IDX_W'(N - 1);
    localparam logic signed [COEF_W-1:0] UNITY_C  = COEF_W'(UNITY);

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_DRAIN  = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic signed [COEF_W-1:0]   shadow [0:N-1];
    logic                       commit_pend_q;
    logic                       swap_q;
    logic                       load_err_q;
    logic [7:0]                 swap_count_q;

    logic beat;
    logic wr_en;
    logic clr_shadow;
    logic err_set;
    logic commit_req;

    assign s_ready    = (state_q != S_COMMIT);
    assign beat       = s_valid && s_ready;
    assign busy       = (state_q != S_LOAD) || (idx_q != '0) || commit_pend_q;
    assign swap       = swap_q;
    assign load_err   = load_err_q;
    assign swap_count = swap_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_LOAD;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        wr_en      = 1'b0;
        clr_shadow = 1'b0;
        err_set    = 1'b0;
        commit_req = 1'b0;
        case (state_q)
            S_LOAD: begin
                if (beat) begin
                    wr_en = 1'b1;
                    if (s_last) begin
                        idx_d = '0;
                        if (idx_q == LAST_IDX) begin
                            state_d = S_COMMIT;
                        end else begin
                            clr_shadow = 1'b1;
                            err_set    = 1'b1;
                        end
                    end else if (idx_q == LAST_IDX) begin
                        state_d = S_DRAIN;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (beat && s_last) begin
                    err_set = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_COMMIT: begin
                commit_req = 1'b1;
                state_d    = S_LOAD;
            end
            default: begin
                state_d = S_LOAD;
                idx_d   = '0;
            end
        endcase
    end

    // A short set also writes its final beat; the clear takes priority so nothing stale survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) shadow[i] <= '0;
        end else if (clr_shadow) begin
            for (int i = 0; i < N; i++) shadow[i] <= '0;
        end else if (wr_en) begin
            shadow[idx_q] <= s_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            commit_pend_q <= 1'b0;
            swap_q        <= 1'b0;
        end else begin
            commit_pend_q <= commit_req;
            swap_q        <= commit_pend_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_out[0] <= UNITY_C;
            for (int i = 1; i < N; i++) h_out[i] <= '0;
        end else if (commit_pend_q) begin
            for (int i = 0; i < N; i++) h_out[i] <= shadow[i];
        end
    end

    // Commit has priority over a coincident framing error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_err_q   <= 1'b0;
            swap_count_q <= '0;
        end else if (commit_pend_q) begin
            load_err_q   <= 1'b0;
            swap_count_q <= swap_count_q + 8'd1;
        end else if (err_set) begin
            load_err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fir_coef_loader.sv
// Randomized bench for fir_coef_loader: drives framed, short, long and gapped coefficient sets
// and checks the active bank, swap pulse, error flag and swap counter against a set-level model.
module tb_fir_coef_loader;

    localparam int N = 9;
    localparam int W = 16;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                s_valid = 1'b0;
    logic                s_ready;
    logic signed [W-1:0] s_data = '0;
    logic                s_last = 1'b0;
    logic signed [W-1:0] h_out [0:N-1];
    logic                swap;
    logic                load_err;
    logic                busy;
    logic [7:0]          swap_count;

    int checks = 0;
    int failures = 0;

    logic signed [W-1:0] ref_h [0:N-1];
    logic signed [W-1:0] set_vals [0:15];
    int                  ref_cnt;
    bit                  ref_err;

    fir_coef_loader #(.N(N), .COEF_W(W), .UNITY(32767)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_last(s_last), .h_out(h_out), .swap(swap), .load_err(load_err), .busy(busy),
        .swap_count(swap_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        ref_h[0] = 16'sd32767;
        for (int i = 1; i < N; i++) ref_h[i] = '0;
        ref_cnt = 0;
        ref_err = 1'b0;
    endtask

    // Drives one beat after `gap` idle cycles; returns at the negedge following its acceptance.
    task automatic drive_beat(input logic signed [W-1:0] d, input bit last, input int gap, input bit chk);
        int  tries;
        bit  acc;
        bit  same;
        for (int g = 0; g < gap; g++) begin
            s_valid = 1'b0;
            if (chk) begin
                checks++;
                if (busy !== 1'b1) begin
                    failures++;
                    $display("FAIL busy_mid_set: got %b want 1", busy);
                end
                same = 1'b1;
                for (int i = 0; i < N; i++) if (h_out[i] !== ref_h[i]) same = 1'b0;
                checks++;
                if (!same) begin
                    failures++;
                    $display("FAIL h_stable_mid_set: h_out[0]=%0d want %0d", h_out[0], ref_h[0]);
                end
            end
            @(negedge clk);
        end
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        tries   = 0;
        acc     = 1'b0;
        while (!acc && tries < 20) begin
            if (chk) begin
                checks++;
                if (busy !== 1'b1) begin
                    failures++;
                    $display("FAIL busy_mid_set: got %b want 1", busy);
                end
            end
            acc = s_ready;
            tries++;
            @(negedge clk);
        end
        checks++;
        if (!acc) begin
            failures++;
            $display("FAIL beat_accept_timeout: s_ready=%b want 1 within 20 cycles", s_ready);
        end
    endtask

    // Sends set_vals[0:len-1]; when post is set, checks the cycle-by-cycle aftermath of the final beat.
    task automatic run_set(input int len, input int maxgap, input bit post);
        bit  full;
        bit  same;
        int  old_cnt;
        full = (len == N);
        for (int k = 0; k < len; k++)
            drive_beat(set_vals[k], k == len - 1, (maxgap > 0) ? $urandom_range(0, maxgap) : 0, k > 0);
        old_cnt = ref_cnt;
        if (!post) begin
            if (full) begin
                for (int i = 0; i < N; i++) ref_h[i] = set_vals[i];
                ref_cnt++;
                ref_err = 1'b0;
            end else begin
                ref_err = 1'b1;
            end
            return;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        // first negedge after the final accept
        checks++;
        if (s_ready !== !full) begin
            failures++;
            $display("FAIL s_ready_after_last: got %b want %b", s_ready, !full);
        end
        checks++;
        if (busy !== full) begin
            failures++;
            $display("FAIL busy_after_last: got %b want %b", busy, full);
        end
        checks++;
        if (load_err !== (full ? ref_err : 1'b1)) begin
            failures++;
            $display("FAIL load_err_after_last: got %b want %b", load_err, full ? ref_err : 1'b1);
        end
        @(negedge clk);
        same = 1'b1;
        for (int i = 0; i < N; i++) if (h_out[i] !== ref_h[i]) same = 1'b0;
        checks++;
        if (!same || swap !== 1'b0 || s_ready !== 1'b1) begin
            failures++;
            $display("FAIL pre_commit_cycle: same=%b swap=%b s_ready=%b want 1 0 1", same, swap, s_ready);
        end
        checks++;
        if (busy !== full) begin
            failures++;
            $display("FAIL busy_commit_pending: got %b want %b", busy, full);
        end
        if (full) begin
            for (int i = 0; i < N; i++) ref_h[i] = set_vals[i];
            ref_cnt++;
            ref_err = 1'b0;
        end else begin
            ref_err = 1'b1;
        end
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (h_out[i] !== ref_h[i]) begin
                failures++;
                $display("FAIL h_out_tap%0d: got %0d want %0d", i, h_out[i], ref_h[i]);
            end
        end
        checks++;
        if (swap !== full) begin
            failures++;
            $display("FAIL swap_pulse: got %b want %b", swap, full);
        end
        checks++;
        if (swap_count !== 8'(ref_cnt)) begin
            failures++;
            $display("FAIL swap_count: got %0d want %0d (prev %0d)", swap_count, 8'(ref_cnt), 8'(old_cnt));
        end
        checks++;
        if (load_err !== ref_err || busy !== 1'b0) begin
            failures++;
            $display("FAIL post_set_flags: load_err=%b busy=%b want %b 0", load_err, busy, ref_err);
        end
        @(negedge clk);
        checks++;
        if (swap !== 1'b0) begin
            failures++;
            $display("FAIL swap_single_cycle: got %b want 0", swap);
        end
    endtask

    task automatic test_reset();
        bit same;
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        same = 1'b1;
        for (int i = 0; i < N; i++) if (h_out[i] !== ref_h[i]) same = 1'b0;
        checks++;
        if (!same) begin
            failures++;
            $display("FAIL reset_h_out: h_out[0]=%0d h_out[1]=%0d want 32767 0", h_out[0], h_out[1]);
        end
        checks++;
        if (s_ready !== 1'b1 || swap !== 1'b0 || load_err !== 1'b0 || busy !== 1'b0 || swap_count !== 8'd0) begin
            failures++;
            $display("FAIL reset_flags: s_ready=%b swap=%b load_err=%b busy=%b swap_count=%0d want 1 0 0 0 0",
                     s_ready, swap, load_err, busy, swap_count);
        end
    endtask

    task automatic test_full_set();
        for (int k = 0; k < N; k++) set_vals[k] = W'(k + 1);
        run_set(N, 0, 1'b1);
    endtask

    task automatic test_random_sets();
        int len;
        for (int it = 0; it < 10; it++) begin
            len = $urandom_range(2, 12);
            if (it % 3 == 0) len = N;
            for (int k = 0; k < 16; k++) set_vals[k] = W'($urandom);
            run_set(len, 3, 1'b1);
        end
    endtask

    task automatic test_gapped_set();
        for (int k = 0; k < N; k++) set_vals[k] = W'(k + 1);
        run_set(N, 5, 1'b1);
    endtask

    task automatic test_short_set();
        for (int k = 0; k < 5; k++) set_vals[k] = W'($urandom);
        run_set(5, 1, 1'b1);
        for (int k = 0; k < N; k++) set_vals[k] = -16'sd1;
        run_set(N, 1, 1'b1);
    endtask

    task automatic test_long_set();
        for (int k = 0; k < 12; k++) set_vals[k] = W'($urandom);
        run_set(12, 1, 1'b1);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < N; k++) set_vals[k] = W'($urandom);
        run_set(N, 0, 1'b0);
        for (int k = 0; k < N; k++) set_vals[k] = W'($urandom);
        run_set(N, 0, 1'b1);
    endtask

    task automatic test_count_wrap();
        for (int s = 0; s < 255; s++) begin
            for (int k = 0; k < N; k++) set_vals[k] = W'($urandom);
            run_set(N, 0, (s % 64) == 0);
        end
        for (int k = 0; k < N; k++) set_vals[k] = W'($urandom);
        run_set(N, 0, 1'b1);
    endtask

    task automatic test_async_reset();
        bit same;
        for (int k = 0; k < N; k++) set_vals[k] = W'($urandom);
        for (int k = 0; k < 4; k++) drive_beat(set_vals[k], 1'b0, 0, k > 0);
        #2;
        rst_n   = 1'b0;
        s_valid = 1'b0;
        #1;
        model_reset();
        same = 1'b1;
        for (int i = 0; i < N; i++) if (h_out[i] !== ref_h[i]) same = 1'b0;
        checks++;
        if (!same) begin
            failures++;
            $display("FAIL async_reset_h_out: h_out[0]=%0d h_out[1]=%0d want 32767 0", h_out[0], h_out[1]);
        end
        checks++;
        if (s_ready !== 1'b1 || busy !== 1'b0 || swap_count !== 8'd0 || load_err !== 1'b0 || swap !== 1'b0) begin
            failures++;
            $display("FAIL async_reset_flags: s_ready=%b busy=%b swap_count=%0d load_err=%b swap=%b want 1 0 0 0 0",
                     s_ready, busy, swap_count, load_err, swap);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < N; k++) set_vals[k] = W'($urandom);
        run_set(N, 2, 1'b1);
    endtask

    initial begin
        test_reset();
        test_full_set();
        test_random_sets();
        test_gapped_set();
        test_short_set();
        test_long_set();
        test_back_to_back();
        test_count_wrap();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
